// File: rtl/sram_ctl_pkg.sv
// rtl/sram_ctl_pkg.sv - shared constants for the SRAM access controller
//
// Purpose: FSM state encodings, arbitration mode codes and default
//          parameter values shared by the controller, its arbiter and benches.
// Ports:   none (package).
package sram_ctl_pkg;

  // FSM state encodings
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_OEIA   = 3'd1;
  localparam logic [2:0] ST_WRITE  = 3'd2;
  localparam logic [2:0] ST_WREND  = 3'd3;
  localparam logic [2:0] ST_RDWAIT = 3'd4;
  localparam logic [2:0] ST_INC    = 3'd5;

  // Arbitration modes
  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Parameter defaults
  localparam int DEF_ADDR_W   = 19;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_NCHAN    = 2;
  localparam int DEF_WR_SETUP = 1;
  localparam int DEF_WE_WIDTH = 1;
  localparam int DEF_RD_WAIT  = 2;

endpackage

// File: rtl/sram_access_controller_if.sv
// rtl/sram_access_controller_if.sv - requester-side bus of the SRAM access controller
//
// Purpose: bundles the per-channel request/acknowledge handshake.
// Signals: REQ/RNW/WDATA (requester -> controller), ACK/RDATA/RVALID
//          (controller -> requester). Channel i write data is
//          WDATA[i*DATA_W +: DATA_W].
// Modports: master = requester side, slave = controller side.
interface sram_access_controller_if #(
  parameter int NCHAN  = 2,
  parameter int DATA_W = 8
);
  logic [NCHAN-1:0]        REQ;
  logic [NCHAN-1:0]        RNW;
  logic [NCHAN*DATA_W-1:0] WDATA;
  logic [NCHAN-1:0]        ACK;
  logic [DATA_W-1:0]       RDATA;
  logic                    RVALID;

  modport master (output REQ, output RNW, output WDATA,
                  input  ACK, input  RDATA, input  RVALID);
  modport slave  (input  REQ, input  RNW, input  WDATA,
                  output ACK, output RDATA, output RVALID);
endinterface

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - NCHAN-way fixed-priority / round-robin arbiter
//
// Purpose: combinational one-hot grant among requesting channels.
// Ports:   clk, rst (sync active-high); req[NCHAN]; take (grant is consumed
//          this cycle, advances the round-robin pointer); grant[NCHAN]
//          one-hot; grant_idx binary index of grant; any (some req high).
module sram_arbiter
  import sram_ctl_pkg::*;
#(
  parameter int NCHAN    = DEF_NCHAN,
  parameter int ARB_MODE = ARB_FIXED,
  localparam int PW      = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCHAN-1:0] req,
  input  logic             take,
  output logic [NCHAN-1:0] grant,
  output logic [PW-1:0]    grant_idx,
  output logic             any
);

  // Last granted channel; reset so channel 0 is searched first.
  logic [PW-1:0] ptr;

  always_comb begin
    int          idx;
    logic [PW-1:0] sel;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    sel       = '0;
    for (int i = 0; i < NCHAN; i++) begin
      // Round-robin searches starting just after the last winner.
      idx = (ARB_MODE == ARB_RR) ? (int'(ptr) + 1 + i) % NCHAN : i;
      sel = PW'(idx);
      if (!any && req[sel]) begin
        any        = 1'b1;
        grant[sel] = 1'b1;
        grant_idx  = sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= PW'(NCHAN - 1);
    end else if (take && any) begin
      ptr <= grant_idx;
    end
  end

endmodule

// File: rtl/sram_access_controller.sv
// rtl/sram_access_controller.sv - multi-channel asynchronous SRAM access controller
//
// Purpose: arbitrates NCHAN requesters onto one asynchronous SRAM with
//          programmable write setup / WE width / read wait, a shared
//          auto-incrementing address counter and EMPTY/FULL flags.
// Ports:   CLOCK, RESET (sync active-high); bus (requester handshake, slave);
//          ADDR_LOAD/ADDR_LOAD_VAL counter load; ADDR/EMPTY/FULL/BUSY status;
//          SRAM_A, SRAM_DQ_O, SRAM_DQ_I, SRAM_DQ_OE, SRAM_WE_n, SRAM_OE_n pins.
module sram_access_controller
  import sram_ctl_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NCHAN    = DEF_NCHAN,
  parameter int ARB_MODE = ARB_FIXED,
  parameter int WR_SETUP = DEF_WR_SETUP,
  parameter int WE_WIDTH = DEF_WE_WIDTH,
  parameter int RD_WAIT  = DEF_RD_WAIT
) (
  input  logic                   CLOCK,
  input  logic                   RESET,
  sram_access_controller_if.slave bus,
  input  logic                   ADDR_LOAD,
  input  logic [ADDR_W-1:0]      ADDR_LOAD_VAL,
  output logic [ADDR_W-1:0]      ADDR,
  output logic                   EMPTY,
  output logic                   FULL,
  output logic                   BUSY,
  output logic [ADDR_W-1:0]      SRAM_A,
  output logic [DATA_W-1:0]      SRAM_DQ_O,
  input  logic [DATA_W-1:0]      SRAM_DQ_I,
  output logic                   SRAM_DQ_OE,
  output logic                   SRAM_WE_n,
  output logic                   SRAM_OE_n
);

  localparam int PW = (NCHAN > 1) ? $clog2(NCHAN) : 1;

  logic [2:0]        state;
  logic [7:0]        cnt;
  logic [NCHAN-1:0]  cur_grant;
  logic              cur_rnw;
  logic [NCHAN-1:0]  ack_q;
  logic [DATA_W-1:0] rdata_q;
  logic              rvalid_q;
  logic              pend_load;
  logic [ADDR_W-1:0] pend_val;
  logic [ADDR_W-1:0] addr_q;
  logic              empty_q;
  logic              full_q;
  logic              busy_q;
  logic [DATA_W-1:0] dq_o_q;
  logic              dq_oe_q;
  logic              we_n_q;
  logic              oe_n_q;

  logic [NCHAN-1:0]  grant;
  logic [PW-1:0]     grant_idx;
  logic              any_req;
  logic              grant_ok;
  logic [DATA_W-1:0] wsel;

  // A load (direct or pending) in IDLE takes the cycle; no grant then.
  assign grant_ok = (state == ST_IDLE) && !ADDR_LOAD && !pend_load;

  sram_arbiter #(.NCHAN(NCHAN), .ARB_MODE(ARB_MODE)) u_arb (
    .clk       (CLOCK),
    .rst       (RESET),
    .req       (bus.REQ),
    .take      (grant_ok),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any_req)
  );

  always_comb begin
    wsel = '0;
    for (int i = 0; i < NCHAN; i++) begin
      if (grant_idx == PW'(i)) wsel = bus.WDATA[i*DATA_W +: DATA_W];
    end
  end

  // Address counter next value. Loads are honoured in IDLE and INC; a load
  // arriving in INC (or pending from earlier in the access) replaces the
  // increment. A full counter only advances on reads.
  logic              load_now;
  logic [ADDR_W-1:0] load_val;
  logic [ADDR_W-1:0] addr_nx;
  logic              full_nx;

  always_comb begin
    load_now = 1'b0;
    load_val = ADDR_LOAD_VAL;
    addr_nx  = addr_q;
    full_nx  = full_q;
    if (state == ST_IDLE || state == ST_INC) begin
      if (ADDR_LOAD) begin
        load_now = 1'b1;
      end else if (pend_load) begin
        load_now = 1'b1;
        load_val = pend_val;
      end
    end
    if (load_now) begin
      addr_nx = load_val;
      full_nx = 1'b0;
    end else if (state == ST_INC) begin
      if (cur_rnw) begin
        addr_nx = addr_q + 1'b1;
      end else if (!full_q) begin
        addr_nx = addr_q + 1'b1;
        full_nx = &addr_q;
      end
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      cur_grant <= '0;
      cur_rnw   <= 1'b0;
      ack_q     <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      pend_load <= 1'b0;
      pend_val  <= '0;
      addr_q    <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      busy_q    <= 1'b0;
      dq_o_q    <= '0;
      dq_oe_q   <= 1'b0;
      we_n_q    <= 1'b1;
      oe_n_q    <= 1'b0;
    end else begin
      ack_q    <= '0;
      rvalid_q <= 1'b0;
      addr_q   <= addr_nx;
      empty_q  <= (addr_nx == '0);
      full_q   <= full_nx;

      if (load_now) begin
        pend_load <= 1'b0;
      end else if (ADDR_LOAD) begin
        pend_load <= 1'b1;
        pend_val  <= ADDR_LOAD_VAL;
      end

      case (state)
        ST_IDLE: begin
          if (grant_ok && any_req) begin
            cur_grant <= grant;
            cur_rnw   <= bus.RNW[grant_idx];
            busy_q    <= 1'b1;
            if (bus.RNW[grant_idx]) begin
              state  <= ST_RDWAIT;
              cnt    <= 8'(RD_WAIT - 1);
              oe_n_q <= 1'b0;
            end else begin
              state   <= ST_OEIA;
              cnt     <= 8'(WR_SETUP - 1);
              dq_o_q  <= wsel;
              oe_n_q  <= 1'b1;
              dq_oe_q <= 1'b1;
            end
          end
        end
        ST_OEIA: begin
          if (cnt == 8'd0) begin
            state  <= ST_WRITE;
            cnt    <= 8'(WE_WIDTH - 1);
            we_n_q <= full_q;  // full: sequence runs, but no strobe
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        ST_WRITE: begin
          if (cnt == 8'd0) begin
            state  <= ST_WREND;
            we_n_q <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        ST_WREND: begin
          state   <= ST_INC;
          ack_q   <= cur_grant;
          oe_n_q  <= 1'b0;
          dq_oe_q <= 1'b0;
        end
        ST_RDWAIT: begin
          if (cnt == 8'd0) begin
            state    <= ST_INC;
            rdata_q  <= SRAM_DQ_I;
            ack_q    <= cur_grant;
            rvalid_q <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        ST_INC: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ACK    = ack_q;
  assign bus.RDATA  = rdata_q;
  assign bus.RVALID = rvalid_q;
  assign ADDR       = addr_q;
  assign EMPTY      = empty_q;
  assign FULL       = full_q;
  assign BUSY       = busy_q;
  assign SRAM_A     = addr_q;
  assign SRAM_DQ_O  = dq_o_q;
  assign SRAM_DQ_OE = dq_oe_q;
  assign SRAM_WE_n  = we_n_q;
  assign SRAM_OE_n  = oe_n_q;

endmodule

// File: tb/tb_sram_access_controller.sv
// tb/tb_sram_access_controller.sv - scoreboard bench for sram_access_controller
module tb_sram_access_controller;
  import sram_ctl_pkg::*;

  logic clk;
  logic rst;

  typedef struct {
    logic [2:0]  ack;
    logic        rvalid;
    logic [7:0]  rdata;
    logic [18:0] addr;
    logic        full;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea;
  exp_t eb;

  int n_chk  = 0;
  int n_fail = 0;

  // DUT A: round-robin with SRAM model
  sram_access_controller_if #(.NCHAN(3), .DATA_W(8)) bus_a();
  logic        a_ld;
  logic [18:0] a_ldv;
  logic [18:0] a_addr, a_sram_a;
  logic        a_empty, a_full, a_busy, a_dq_oe, a_we_n, a_oe_n;
  logic [7:0]  a_dq_o, a_dq_i;

  sram_access_controller #(.ADDR_W(19), .DATA_W(8), .NCHAN(3), .ARB_MODE(ARB_RR),
                           .WR_SETUP(1), .WE_WIDTH(1), .RD_WAIT(2)) dut_a (
    .CLOCK(clk), .RESET(rst), .bus(bus_a.slave),
    .ADDR_LOAD(a_ld), .ADDR_LOAD_VAL(a_ldv), .ADDR(a_addr),
    .EMPTY(a_empty), .FULL(a_full), .BUSY(a_busy),
    .SRAM_A(a_sram_a), .SRAM_DQ_O(a_dq_o), .SRAM_DQ_I(a_dq_i),
    .SRAM_DQ_OE(a_dq_oe), .SRAM_WE_n(a_we_n), .SRAM_OE_n(a_oe_n)
  );

  // DUT B: fixed priority, only used for grant order
  sram_access_controller_if #(.NCHAN(3), .DATA_W(8)) bus_b();
  logic [18:0] b_addr, b_sram_a;
  logic        b_empty, b_full, b_busy, b_dq_oe, b_we_n, b_oe_n;
  logic [7:0]  b_dq_o;

  sram_access_controller #(.ADDR_W(19), .DATA_W(8), .NCHAN(3), .ARB_MODE(ARB_FIXED),
                           .WR_SETUP(1), .WE_WIDTH(1), .RD_WAIT(2)) dut_b (
    .CLOCK(clk), .RESET(rst), .bus(bus_b.slave),
    .ADDR_LOAD(1'b0), .ADDR_LOAD_VAL(19'h0), .ADDR(b_addr),
    .EMPTY(b_empty), .FULL(b_full), .BUSY(b_busy),
    .SRAM_A(b_sram_a), .SRAM_DQ_O(b_dq_o), .SRAM_DQ_I(8'h00),
    .SRAM_DQ_OE(b_dq_oe), .SRAM_WE_n(b_we_n), .SRAM_OE_n(b_oe_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: preload, then capture any write strobe once per cycle.
  logic [7:0] mem [0:524287];
  initial begin
    for (int i = 0; i < 524288; i++) mem[i] = 8'h00;
    for (int k = 0; k < 6; k++) mem[k] = 8'h50 + 8'(k);
    mem[19'h00020] = 8'h3C;
    forever begin
      @(negedge clk);
      if (!a_we_n) mem[a_sram_a] = a_dq_o;
    end
  end
  assign a_dq_i = a_oe_n ? 8'h00 : mem[a_sram_a];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [2:0] ack, input logic rv, input logic [7:0] rd,
                              input logic [18:0] ad, input logic fu);
    exp_t e;
    e.ack = ack; e.rvalid = rv; e.rdata = rd; e.addr = ad; e.full = fu;
    return e;
  endfunction

  // Scoreboard monitors
  always @(negedge clk) begin
    if (!rst && (bus_a.ACK != 3'b000)) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_ack", 32'(bus_a.ACK), 32'h0);
      end else begin
        ea = qa.pop_front();
        chk("a_ack", 32'(bus_a.ACK), 32'(ea.ack));
        chk("a_rvalid", 32'(bus_a.RVALID), 32'(ea.rvalid));
        if (ea.rvalid) chk("a_rdata", 32'(bus_a.RDATA), 32'(ea.rdata));
        @(negedge clk);
        chk("a_addr", 32'(a_addr), 32'(ea.addr));
        chk("a_full", 32'(a_full), 32'(ea.full));
        chk("a_empty", 32'(a_empty), 32'(ea.addr == 19'h0));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && (bus_b.ACK != 3'b000)) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_ack", 32'(bus_b.ACK), 32'h0);
      end else begin
        eb = qb.pop_front();
        chk("b_ack", 32'(bus_b.ACK), 32'(eb.ack));
        chk("b_rvalid", 32'(bus_b.RVALID), 32'(eb.rvalid));
        @(negedge clk);
        chk("b_addr", 32'(b_addr), 32'(eb.addr));
      end
    end
  end

  task automatic load_a(input logic [18:0] v);
    @(posedge clk); #1;
    a_ld = 1'b1; a_ldv = v;
    @(posedge clk); #1;
    a_ld = 1'b0;
  endtask

  // Issue one access on DUT A; checks ACK latency (negedges from REQ) and WE_n low count.
  task automatic access_a(input int ch, input logic rnw, input logic [7:0] wd,
                          input int exp_lat, input int exp_we);
    int n, we_lo;
    n = 0; we_lo = 0;
    bus_a.RNW[ch] = rnw;
    bus_a.WDATA[ch*8 +: 8] = wd;
    bus_a.REQ[ch] = 1'b1;
    do begin
      @(negedge clk);
      n++;
      if (!a_we_n) we_lo++;
    end while (!bus_a.ACK[ch] && n < 50);
    chk("ack_latency", 32'(n), 32'(exp_lat));
    chk("we_low_cycles", 32'(we_lo), 32'(exp_we));
    @(posedge clk); #1;
    bus_a.REQ[ch] = 1'b0;
  endtask

  int na, nb, cyc, wcyc;

  initial begin
    rst = 1'b1; a_ld = 1'b0; a_ldv = '0;
    bus_a.REQ = '0; bus_a.RNW = '0; bus_a.WDATA = '0;
    bus_b.REQ = '0; bus_b.RNW = '0; bus_b.WDATA = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_we_n", 32'(a_we_n), 32'h1);
    chk("rst_oe_n", 32'(a_oe_n), 32'h0);
    chk("rst_dq_oe", 32'(a_dq_oe), 32'h0);
    chk("rst_ack", 32'(bus_a.ACK), 32'h0);
    chk("rst_rvalid", 32'(bus_a.RVALID), 32'h0);
    chk("rst_rdata", 32'(bus_a.RDATA), 32'h0);
    chk("rst_addr", 32'(a_addr), 32'h0);
    chk("rst_empty", 32'(a_empty), 32'h1);
    chk("rst_full", 32'(a_full), 32'h0);
    chk("rst_busy", 32'(a_busy), 32'h0);

    // ch1 write 0xA5 at 0x10
    load_a(19'h00010);
    chk("load_addr", 32'(a_addr), 32'h10);
    qa.push_back(mk(3'b010, 1'b0, 8'h00, 19'h00011, 1'b0));
    access_a(1, 1'b0, 8'hA5, 5, 1);
    chk("wr1_empty", 32'(a_empty), 32'h0);
    chk("wr1_mem", 32'(mem[19'h00010]), 32'hA5);

    // ch0 read of 0x3C at 0x20
    load_a(19'h00020);
    qa.push_back(mk(3'b001, 1'b1, 8'h3C, 19'h00021, 1'b0));
    access_a(0, 1'b1, 8'h00, 4, 0);

    // Arbitration: all three channels held high for six reads on both DUTs
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      qa.push_back(mk(3'(1 << (k % 3)), 1'b1, 8'h50 + 8'(k), 19'(k + 1), 1'b0));
      qb.push_back(mk(3'b001, 1'b1, 8'h00, 19'(k + 1), 1'b0));
    end
    bus_a.RNW = '1; bus_b.RNW = '1;
    bus_a.REQ = '1; bus_b.REQ = '1;
    na = 0; nb = 0; cyc = 0;
    while (na < 6 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (bus_a.ACK != 3'b000) na++;
      if (bus_b.ACK != 3'b000) nb++;
    end
    chk("rr_ack_count_a", 32'(na), 32'd6);
    chk("fp_ack_count_b", 32'(nb), 32'd6);
    @(posedge clk); #1;
    bus_a.REQ = '0; bus_b.REQ = '0;

    // FULL handling at the top address
    load_a(19'h7FFFF);
    qa.push_back(mk(3'b001, 1'b0, 8'h00, 19'h00000, 1'b1));
    access_a(0, 1'b0, 8'h11, 5, 1);
    qa.push_back(mk(3'b001, 1'b0, 8'h00, 19'h00000, 1'b1));
    access_a(0, 1'b0, 8'h22, 5, 0);
    chk("full_mem_top", 32'(mem[19'h7FFFF]), 32'h11);
    chk("full_mem_zero_untouched", 32'(mem[19'h00000]), 32'h50);
    load_a(19'h00000);
    chk("load_clears_full", 32'(a_full), 32'h0);
    chk("load_zero_empty", 32'(a_empty), 32'h1);

    // ADDR_LOAD during WRITE replaces the increment
    qa.push_back(mk(3'b100, 1'b0, 8'h00, 19'h00100, 1'b0));
    fork
      access_a(2, 1'b0, 8'h77, 5, 1);
      begin
        wcyc = 0;
        do begin
          @(negedge clk);
          wcyc++;
        end while (a_we_n && wcyc < 50);
        a_ld = 1'b1; a_ldv = 19'h00100;
        @(posedge clk); #1;
        a_ld = 1'b0;
      end
    join
    chk("pend_mem", 32'(mem[19'h00000]), 32'h77);
    repeat (3) @(negedge clk);
    chk("pend_no_grant_busy", 32'(a_busy), 32'h0);
    chk("pend_addr_stable", 32'(a_addr), 32'h100);

    // Reset in WRITE abandons the access
    @(posedge clk); #1;
    bus_a.RNW[1] = 1'b0; bus_a.WDATA[15:8] = 8'h99; bus_a.REQ[1] = 1'b1;
    wcyc = 0;
    do begin
      @(negedge clk);
      wcyc++;
    end while (a_we_n && wcyc < 50);
    chk("rstw_we_seen", 32'(a_we_n), 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rstw_we_n", 32'(a_we_n), 32'h1);
    chk("rstw_oe_n", 32'(a_oe_n), 32'h0);
    chk("rstw_addr", 32'(a_addr), 32'h0);
    chk("rstw_ack", 32'(bus_a.ACK), 32'h0);
    chk("rstw_busy", 32'(a_busy), 32'h0);
    bus_a.REQ = '0;
    @(posedge clk); #1 rst = 1'b0;

    repeat (10) @(posedge clk);
    chk("a_queue_drained", 32'(qa.size()), 32'h0);
    chk("b_queue_drained", 32'(qb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_access_controller.md
Name: sram_access_controller

Overview:
Parametrised successor to the single-port SRAM memory write controller and address counter. It arbitrates NCHAN requesters (acquisition engine, MCU data port, future write-path) onto one asynchronous SRAM. Both reads and writes are supported, with programmable setup/strobe/wait timing, a shared auto-incrementing address counter, and full/empty flags. It sits between the register file/acquisition blocks and the SRAM pins, replacing the ad-hoc MWC state machine.

Parameters:
ADDR_W, 19, SRAM address width
DATA_W, 8, SRAM data width
NCHAN, 2, number of requester channels (1..8); channel 0 is the acquisition engine
ARB_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin
WR_SETUP, 1, cycles with OE inactive before WE asserts (>=1)
WE_WIDTH, 1, cycles WE held low (>=1)
RD_WAIT, 2, cycles OE held low before read data is sampled (>=1)

Ports:
CLOCK  in  1  master clock (40 MHz)
RESET  in  1  synchronous, active-high reset
REQ  in  NCHAN  per-channel access request; held high until ACK
RNW  in  NCHAN  per-channel 1 = read, 0 = write; stable while REQ high
WDATA  in  NCHAN*DATA_W  per-channel write data; channel i occupies bits [i*DATA_W +: DATA_W]
ACK  out  NCHAN  one-cycle completion pulse for the granted channel
RDATA  out  DATA_W  last read data; holds its value between reads
RVALID  out  1  one-cycle pulse, coincident with ACK, on read completion
ADDR_LOAD  in  1  load the address counter
ADDR_LOAD_VAL  in  ADDR_W  value to load
ADDR  out  ADDR_W  current address counter value
EMPTY  out  1  ADDR == 0
FULL  out  1  a write has completed at address all-ones
BUSY  out  1  state != IDLE
SRAM_A  out  ADDR_W  SRAM address (equals ADDR)
SRAM_DQ_O  out  DATA_W  data driven to the SRAM
SRAM_DQ_I  in  DATA_W  data from the SRAM
SRAM_DQ_OE  out  1  tri-state enable for SRAM_DQ_O; high only while SRAM_OE_n is high
SRAM_WE_n  out  1  SRAM write enable, active low
SRAM_OE_n  out  1  SRAM output enable, active low

Behaviour:
- Reset values: state IDLE, SRAM_WE_n=1, SRAM_OE_n=0, SRAM_DQ_OE=0, ACK=0, RVALID=0, RDATA=0, ADDR=0, EMPTY=1, FULL=0, BUSY=0, round-robin pointer=NCHAN-1, pending load cleared.
- Reset mid-access: the access is abandoned with no ACK; WE_n returns high on the next edge.
- All outputs are registered.
- States: IDLE, OEIA, WRITE, WREND, RDWAIT, INC.
- IDLE:
  - WE_n=1, OE_n=0.
  - If ADDR_LOAD is high: load the counter, stay in IDLE, grant nothing that cycle.
  - Else if any REQ is high: grant one channel and latch its RNW and WDATA.
    - Write goes to OEIA.
    - Read goes to RDWAIT.
- Arbitration:
  - Mode 0: lowest requesting index wins.
  - Mode 1: first requesting index after the last granted channel, wrapping modulo NCHAN.
- Write path:
  - OEIA: OE_n=1, DQ_OE=1; lasts WR_SETUP cycles.
  - WRITE: WE_n=0; lasts WE_WIDTH cycles.
  - WREND: WE_n=1; 1 cycle.
  - INC: ACK, increment; 1 cycle.
  - SRAM_A and SRAM_DQ_O are stable from OEIA through WREND.
- Read path:
  - RDWAIT: OE_n=0; lasts RD_WAIT cycles.
  - INC: RDATA <= SRAM_DQ_I sampled on the final RDWAIT edge; ACK and RVALID pulse.
- ACK timing: ACK is high during INC.
  - Default write: ACK 4 cycles after the grant edge.
  - Default read: ACK 3 cycles after the grant edge.
  - REQ is re-sampled in IDLE, so back-to-back accesses have 1 IDLE cycle between them.
- Address counter in INC:
  - ADDR <= ADDR+1, wrapping from all-ones to 0.
  - A write completing at ADDR = all-ones sets FULL; ADDR then wraps to 0.
  - While FULL=1, writes run the full state sequence and ACK but keep WE_n high and do not increment. Reads still increment.
- ADDR_LOAD while not IDLE: latched as pending, using the last value presented.
  - The pending load replaces the increment in INC.
  - Any load clears FULL.
  - Requester REQ deasserted before ACK: protocol violation; the access completes regardless.

Decomposition:
- Shared package sram_ctl_pkg: state enumeration, ARB_MODE constants (ARB_FIXED=0, ARB_RR=1), and timing parameter defaults.
- One sub-module, sram_arbiter: NCHAN-way fixed/round-robin grant with one-hot output, combinational grant plus registered pointer.

Test Plan:
- Reset, then ch1 write 0xA5 at load 0x00010 -> OE_n rises, WE_n low exactly 1 cycle, ACK[1] 4 cycles after grant, ADDR=0x00011, EMPTY=0.
- Read with preloaded SRAM model 0x3C at 0x00020 -> RDATA=0x3C, RVALID and ACK[0] coincident, WE_n never low, ADDR=0x00021.
- ARB_MODE=1, NCHAN=3, all REQ held high for 6 accesses -> grant order 0,1,2,0,1,2; with ARB_MODE=0 -> grant order 0,0,0...
- Load 0x7FFFF, write twice -> first write sets FULL=1, ADDR=0; second write ACKs with no WE_n pulse; ADDR_LOAD 0 clears FULL.
- ADDR_LOAD 0x00100 asserted during WRITE state -> INC loads 0x00100 (not +1); no spurious grant.
- RESET asserted in WRITE state -> next cycle WE_n=1, OE_n=0, ADDR=0, no ACK.
